// File: rtl/control_sequencer.sv
// Registered control sequencer: assembles two-word immediate instructions and
// emits one control word per instruction. Optional interrupt entry: CU_INTR_EN.
module control_sequencer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    fetch_data,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 intr_req,
    output logic                 intr_ack,
    output logic                 ctrl_valid,
    output logic [27+REG_AW:0]   ctrl_word,
    output logic [DATA_W-1:0]    imm_out
);

    typedef struct packed {
        logic              ior, iow, ops, alu, mr, mw, wb, jmp, jcond;
        logic              sp, spop, jwsp, imm, stackPc, stackFlags, rsEn, rtEn;
        logic [1:0]        fd;
        logic [1:0]        flagSel;
        logic [2:0]        aluOps;
        logic [REG_AW-1:0] wbAddr;
        logic [3:0]        opcode;
    } ctrl_t;

    typedef enum logic [2:0] {
        S_DECODE   = 3'd0,
        S_IMM_WAIT = 3'd1
`ifdef CU_INTR_EN
        ,
        S_INT_PC    = 3'd2,
        S_INT_FLAGS = 3'd3,
        S_INT_JMP   = 3'd4
`endif
    } state_t;

    state_t            r_state, w_stateNext;
    ctrl_t             r_ctrlWord, w_wordNext;
    ctrl_t             r_pendWord, w_pendNext;
    ctrl_t             w_dec;
    logic              r_ctrlValid, w_validNext;
    logic [DATA_W-1:0] r_immOut, w_immNext;
    logic              w_twoWord;
    logic              w_intrTake;
    logic              w_accept;

    logic [3:0]        w_opcode;
    logic [REG_AW-1:0] w_ra;
    logic [REG_AW-1:0] w_rb;

    assign w_opcode = fetch_data[4+2*REG_AW-1 -: 4];
    assign w_ra     = fetch_data[2*REG_AW-1 -: REG_AW];
    assign w_rb     = fetch_data[REG_AW-1:0];

`ifdef CU_INTR_EN
    logic r_inIsr, w_inIsrNext;
    logic r_intrAck, w_ackNext;
    logic w_isRti;

    assign w_intrTake = intr_req && !r_inIsr && (r_state == S_DECODE);
    assign intr_ack   = r_intrAck;
`else
    logic w_unusedIntr;

    assign w_unusedIntr = intr_req;
    assign w_intrTake   = 1'b0;
    assign intr_ack     = 1'b0;
`endif

    assign fetch_ready = !stall &&
                         ((r_state == S_DECODE && !w_intrTake) || r_state == S_IMM_WAIT);
    assign w_accept    = fetch_valid && fetch_ready;
    assign ctrl_valid  = r_ctrlValid;
    assign ctrl_word   = r_ctrlWord;
    assign imm_out     = r_immOut;

    // Instruction decode of the current fetch word; sub-ops are selected by ra[1:0].
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_opcode;
        w_twoWord    = 1'b0;
`ifdef CU_INTR_EN
        w_isRti      = 1'b0;
`endif
        case (w_opcode)
            4'd1: begin
                w_dec.alu = 1'b1; w_dec.wb = 1'b1; w_dec.rtEn = 1'b1;
                w_dec.fd = 2'b10; w_dec.wbAddr = w_rb;
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
                w_dec.alu = 1'b1; w_dec.wb = 1'b1; w_dec.rsEn = 1'b1; w_dec.rtEn = 1'b1;
                w_dec.aluOps = w_opcode[2:0] - 3'd2; w_dec.wbAddr = w_ra;
            end
            4'd7: begin
                case (w_ra[1:0])
                    2'd0: begin w_dec.sp = 1'b1; w_dec.mw = 1'b1; w_dec.rsEn = 1'b1; w_dec.rtEn = 1'b1; end
                    2'd1: begin
                        w_dec.sp = 1'b1; w_dec.spop = 1'b1; w_dec.mr = 1'b1; w_dec.wb = 1'b1;
                        w_dec.wbAddr = w_rb;
                    end
                    2'd2: begin w_dec.iow = 1'b1; w_dec.rtEn = 1'b1; end
                    default: begin w_dec.ior = 1'b1; w_dec.wb = 1'b1; w_dec.wbAddr = w_rb; end
                endcase
            end
            4'd8: begin
                w_dec.ops = 1'b1; w_dec.alu = 1'b1; w_dec.wb = 1'b1; w_dec.rtEn = 1'b1;
                w_dec.aluOps = {1'b1, w_ra[1:0]}; w_dec.wbAddr = w_rb;
            end
            4'd9: begin
                w_dec.jmp = 1'b1; w_dec.jcond = 1'b1; w_dec.rtEn = 1'b1; w_dec.flagSel = w_ra[1:0];
            end
            4'd10: begin
                w_dec.ops = 1'b1; w_dec.jmp = 1'b1; w_dec.alu = 1'b1; w_dec.wb = 1'b1;
                w_dec.rsEn = 1'b1; w_dec.rtEn = 1'b1; w_dec.wbAddr = w_ra;
            end
            4'd11: begin
                case (w_ra[1:0])
                    2'd0: begin w_dec.jmp = 1'b1; w_dec.rtEn = 1'b1; end
                    2'd1: begin
                        w_dec.jmp = 1'b1; w_dec.stackPc = 1'b1; w_dec.sp = 1'b1;
                        w_dec.mw = 1'b1; w_dec.rtEn = 1'b1;
                    end
                    2'd2: begin w_dec.jwsp = 1'b1; w_dec.sp = 1'b1; w_dec.spop = 1'b1; w_dec.mr = 1'b1; end
                    default: begin
                        w_dec.jwsp = 1'b1; w_dec.sp = 1'b1; w_dec.spop = 1'b1; w_dec.mr = 1'b1;
`ifdef CU_INTR_EN
                        w_dec.stackFlags = 1'b1;
                        w_isRti = 1'b1;
`endif
                    end
                endcase
            end
            4'd12: begin
                case (w_ra[1:0])
                    2'd0: begin
                        w_dec.imm = 1'b1; w_dec.wb = 1'b1; w_dec.wbAddr = w_rb; w_twoWord = 1'b1;
                    end
                    2'd1: begin
                        w_dec.imm = 1'b1; w_dec.mr = 1'b1; w_dec.wb = 1'b1;
                        w_dec.wbAddr = w_rb; w_twoWord = 1'b1;
                    end
                    2'd2: begin
                        w_dec.imm = 1'b1; w_dec.mw = 1'b1; w_dec.rtEn = 1'b1; w_twoWord = 1'b1;
                    end
                    default: ;
                endcase
            end
            4'd13: begin
                w_dec.mr = 1'b1; w_dec.wb = 1'b1; w_dec.rsEn = 1'b1; w_dec.wbAddr = w_rb;
            end
            4'd14: begin w_dec.mw = 1'b1; w_dec.rsEn = 1'b1; w_dec.rtEn = 1'b1; end
            default: ;
        endcase
    end

    // Next-state and output selection; flush cannot abort an interrupt entry.
    always_comb begin
        w_stateNext = r_state;
        w_validNext = 1'b0;
        w_wordNext  = r_ctrlWord;
        w_pendNext  = r_pendWord;
        w_immNext   = r_immOut;
`ifdef CU_INTR_EN
        w_ackNext   = 1'b0;
        w_inIsrNext = r_inIsr;
`endif
        case (r_state)
            S_DECODE: begin
                if (flush) begin
                    w_wordNext = '0;
                end
`ifdef CU_INTR_EN
                else if (w_intrTake) begin
                    w_stateNext        = S_INT_PC;
                    w_validNext        = 1'b1;
                    w_wordNext         = '0;
                    w_wordNext.sp      = 1'b1;
                    w_wordNext.mw      = 1'b1;
                    w_wordNext.stackPc = 1'b1;
                    w_inIsrNext        = 1'b1;
                end
`endif
                else if (w_accept) begin
                    if (w_twoWord) begin
                        w_pendNext  = w_dec;
                        w_stateNext = S_IMM_WAIT;
                    end else begin
                        w_wordNext  = w_dec;
                        w_validNext = 1'b1;
`ifdef CU_INTR_EN
                        if (w_isRti) w_inIsrNext = 1'b0;
`endif
                    end
                end
            end
            S_IMM_WAIT: begin
                if (flush) begin
                    w_wordNext  = '0;
                    w_stateNext = S_DECODE;
                end else if (w_accept) begin
                    w_immNext   = fetch_data;
                    w_wordNext  = r_pendWord;
                    w_validNext = 1'b1;
                    w_stateNext = S_DECODE;
                end
            end
`ifdef CU_INTR_EN
            S_INT_PC: begin
                w_stateNext           = S_INT_FLAGS;
                w_validNext           = 1'b1;
                w_wordNext            = '0;
                w_wordNext.sp         = 1'b1;
                w_wordNext.mw         = 1'b1;
                w_wordNext.stackFlags = 1'b1;
            end
            S_INT_FLAGS: begin
                w_stateNext    = S_INT_JMP;
                w_validNext    = 1'b1;
                w_wordNext     = '0;
                w_wordNext.jmp = 1'b1;
                w_wordNext.mr  = 1'b1;
                w_ackNext      = 1'b1;
            end
            S_INT_JMP: begin
                w_stateNext = S_DECODE;
            end
`endif
            default: w_stateNext = S_DECODE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_DECODE;
        end else if (!stall) begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrlValid <= 1'b0;
            r_ctrlWord  <= '0;
            r_pendWord  <= '0;
            r_immOut    <= '0;
`ifdef CU_INTR_EN
            r_intrAck   <= 1'b0;
            r_inIsr     <= 1'b0;
`endif
        end else if (!stall) begin
            r_ctrlValid <= w_validNext;
            r_ctrlWord  <= w_wordNext;
            r_pendWord  <= w_pendNext;
            r_immOut    <= w_immNext;
`ifdef CU_INTR_EN
            r_intrAck   <= w_ackNext;
            r_inIsr     <= w_inIsrNext;
`endif
        end
    end

endmodule
